operand_dispatcher: RTL

Upstream feeder for the sequential shift-add multiplier. Buffers operand pairs from a valid/ready producer in a small FIFO and issues them one at a time. For each pair it pulses start with the operands held stable, then waits for the multiplier's finished pulse before issuing the next. The multiplier itself has no backpressure and no queueing; this block provides both.

---
 rtl/operand_dispatcher_pkg.sv | 22 ++
 rtl/operand_dispatcher_if.sv | 39 +++
 rtl/operand_dispatcher_fifo.sv | 62 ++++++
 rtl/operand_dispatcher.sv | 127 ++++++++++++
 4 files changed

// File: rtl/operand_dispatcher_pkg.sv
// Shared types and constants for the operand dispatcher slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package operand_dispatcher_pkg;

    // Dispatcher FSM: IDLE waits for work, ISSUE is the one-cycle start pulse,
    // WAIT holds the operands until the multiplier reports completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Width of the optional issued-operation counter.
    localparam int STATS_W = 16;

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/operand_dispatcher_if.sv
// Bundle of producer-side and multiplier-side signals for the dispatcher.
// Latency: n/a (wiring only).
// Backpressure: o_ready back to the producer; the multiplier side has none.
//
// Signals (directions as seen by the dispatcher, i.e. the slave modport):
//   i_valid, i_multiplicand, i_multiplier : producer operand pair + valid
//   o_ready                               : dispatcher can accept a pair
//   o_start, o_multiplicand, o_multiplier : issue to the multiplier
//   i_finished                            : multiplier completion pulse
//   o_busy, o_count                       : status (FSM active, FIFO occupancy)
// master: the environment (producer + multiplier); slave: the dispatcher.
interface operand_dispatcher_if
    import operand_dispatcher_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
);
    logic                         i_valid;
    logic                         o_ready;
    logic [BITS-1:0]              i_multiplicand;
    logic [BITS-1:0]              i_multiplier;
    logic                         o_start;
    logic [BITS-1:0]              o_multiplicand;
    logic [BITS-1:0]              o_multiplier;
    logic                         i_finished;
    logic                         o_busy;
    logic [occ_width(DEPTH)-1:0]  o_count;

    modport master (
        output i_valid, i_multiplicand, i_multiplier, i_finished,
        input  o_ready, o_start, o_multiplicand, o_multiplier, o_busy, o_count
    );

    modport slave (
        input  i_valid, i_multiplicand, i_multiplier, i_finished,
        output o_ready, o_start, o_multiplicand, o_multiplier, o_busy, o_count
    );

endinterface

// File: rtl/operand_dispatcher_fifo.sv
// operand_fifo: circular buffer holding operand pairs between producer and FSM.
// Latency: a pushed entry is visible at o_rdata / counted in o_count the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored internally.
//
// Ports: i_clock, i_reset (async, active-high); i_push/i_wdata/o_full write side;
//        i_pop/o_rdata/o_empty read side (o_rdata is the current head, combinational);
//        o_count occupancy 0..DEPTH.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module operand_fifo
    import operand_dispatcher_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_wdata,
    output logic                        o_full,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_rdata,
    output logic                        o_empty,
    output logic [occ_width(DEPTH)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    // Full refuses a push even when a pop happens on the same edge.
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;
    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge i_clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/operand_dispatcher.sv
// operand_dispatcher: queues operand pairs and issues them one at a time to a shift-add multiplier.
// Latency: push at E0 into an idle, empty block -> pop at E1 -> o_start high the cycle after E1.
// Backpressure: o_ready = FIFO not full; the next pair waits in WAIT until i_finished.
//
// Ports: i_clock, i_reset (async, active-high); bus (operand_dispatcher_if.slave) carries the
//        producer handshake, multiplier issue/finish signals and o_busy/o_count status.
// Optional macro OPERAND_DISPATCHER_STATS_EN adds o_issued (pop counter, wraps) and
//        o_overflow (sticky: valid seen while not ready).
module operand_dispatcher
    import operand_dispatcher_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    operand_dispatcher_if.slave bus
`ifdef OPERAND_DISPATCHER_STATS_EN
    ,
    output logic [STATS_W-1:0]  o_issued,
    output logic                o_overflow
`endif
);
    localparam int CW = occ_width(DEPTH);

    state_e            state_q, state_d;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [2*BITS-1:0] head;
    logic [CW-1:0]     count;
    logic [BITS-1:0]   mcand_q, mcand_d;
    logic [BITS-1:0]   mplier_q, mplier_d;

    operand_fifo #(
        .WIDTH (2*BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (bus.i_valid),
        .i_wdata ({bus.i_multiplicand, bus.i_multiplier}),
        .o_full  (fifo_full),
        .i_pop   (pop),
        .o_rdata (head),
        .o_empty (fifo_empty),
        .o_count (count)
    );

    // Next state and pop decision. i_finished only matters in WAIT; a finish
    // with work queued goes straight back to ISSUE so the multiplier idles
    // for just one cycle between operations.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                    pop     = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.i_finished) begin
                    if (!fifo_empty) begin
                        state_d = ST_ISSUE;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands load only on a pop so they stay stable from issue to finish
    // and keep their last values while idle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (pop) begin
            mcand_d  = head[2*BITS-1:BITS];
            mplier_d = head[BITS-1:0];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Start is decoded from the state register, so it is glitch-free and
    // drops asynchronously with reset.
    assign bus.o_start        = (state_q == ST_ISSUE);
    assign bus.o_busy         = (state_q != ST_IDLE);
    assign bus.o_ready        = ~fifo_full;
    assign bus.o_count        = count;
    assign bus.o_multiplicand = mcand_q;
    assign bus.o_multiplier   = mplier_q;

`ifdef OPERAND_DISPATCHER_STATS_EN
    logic [STATS_W-1:0] issued_q;
    logic               overflow_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            issued_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) issued_q <= issued_q + STATS_W'(1);
            if (bus.i_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign o_issued   = issued_q;
    assign o_overflow = overflow_q;
`endif

endmodule
